// File: rtl/uart_reg_bank_pkg.sv
// Shared register map and CTRL bit layout for the UART register bank.
// Also holds the debounce counter sizing helper.
package uart_reg_bank_pkg;

   typedef enum logic [7:0] {
      REG_ID       = 8'h00,
      REG_LED      = 8'h01,
      REG_BTN_LIVE = 8'h02,
      REG_EVENTS   = 8'h03,
      REG_IRQ_MASK = 8'h04,
      REG_CNT_LO   = 8'h05,
      REG_CNT_HI   = 8'h06,
      REG_CTRL     = 8'h07,
      REG_SCRATCH0 = 8'h10
   } reg_addr_e;

   localparam int CTRL_RUN   = 0;
   localparam int CTRL_CLEAR = 1;
   localparam int CTRL_OVF   = 2;

   // Bits needed to count 0..n inclusive.
   function automatic int cnt_bits(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/uart_reg_bank_button_debouncer.sv
// Single-bit button conditioner: 2-flop synchroniser, stability counter,
// and a rise flag asserted in the cycle before the debounced level goes high.
module button_debouncer
   import uart_reg_bank_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = cnt_bits(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic [CW-1:0] cnt_reg;
   logic          differ;

   assign differ = (sync2_reg != level_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         // Any cycle of agreement restarts the stability count.
         if (!differ) begin
            cnt_reg <= '0;
         end else if (cnt_reg == LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign level = level_reg;
   assign rise  = differ && (cnt_reg == LAST) && sync2_reg;

endmodule

// File: rtl/uart_reg_bank.sv
// Register bank behind the UART control block: ID, LEDs, debounced buttons with
// W1C events and IRQ mask, run/clear cycle counter with atomic wide read, scratch.
module uart_reg_bank
   import uart_reg_bank_pkg::*;
#(
   parameter int          DATA_WIDTH      = 32,
   parameter int          NUM_BUTTONS     = 4,
   parameter int          NUM_LEDS        = 8,
   parameter int          NUM_SCRATCH     = 4,
   parameter int          CNT_WIDTH       = 48,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] ID_VALUE        = 32'h46520001
)(
   input  logic                   ipClk,
   input  logic                   ipnReset,
   input  logic [7:0]             ipAddress,
   input  logic [DATA_WIDTH-1:0]  ipWrData,
   input  logic                   ipWrEnable,
   input  logic                   ipRdEnable,
   output logic [DATA_WIDTH-1:0]  opRdData,
   output logic                   opRdValid,
   output logic                   opAddrErr,
   input  logic [NUM_BUTTONS-1:0] ipButtons,
   output logic [NUM_LEDS-1:0]    opLED,
   output logic                   opIrq
);

   localparam int DW = DATA_WIDTH;
   localparam int HW = CNT_WIDTH - DATA_WIDTH;
   localparam int SW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

   logic [NUM_BUTTONS-1:0] btn_level;
   logic [NUM_BUTTONS-1:0] btn_rise;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
         button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debouncer (
            .clk   (ipClk),
            .rst_n (ipnReset),
            .raw   (ipButtons[gi]),
            .level (btn_level[gi]),
            .rise  (btn_rise[gi])
         );
      end
   endgenerate

   logic [NUM_LEDS-1:0]    led_reg;
   logic [NUM_BUTTONS-1:0] events_reg, events_next;
   logic [NUM_BUTTONS-1:0] irq_mask_reg;
   logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
   logic [HW-1:0]          cnt_hi_reg;
   logic                   run_reg;
   logic                   ovf_reg, ovf_next;
   logic                   irq_reg;
   logic [DW-1:0]          rd_data_reg;
   logic                   rd_valid_reg;
   logic                   addr_err_reg;

   logic          is_scratch;
   logic          mapped;
   logic [SW-1:0] scratch_sel;
   logic          wr_led, wr_events, wr_mask, wr_ctrl, wr_scratch;
   logic          rd_cnt_lo;
   logic          clear_cmd;
   logic          wrap;
   logic [DW-1:0] rd_mux;
   logic [DW-1:0] scratch_val [NUM_SCRATCH];

   always_comb begin
      is_scratch  = (ipAddress[7:4] == 4'h1) && ({1'b0, ipAddress[3:0]} < 5'(NUM_SCRATCH));
      mapped      = (ipAddress <= REG_CTRL) || is_scratch;
      scratch_sel = ipAddress[SW-1:0];
      wr_led      = ipWrEnable && (ipAddress == REG_LED);
      wr_events   = ipWrEnable && (ipAddress == REG_EVENTS);
      wr_mask     = ipWrEnable && (ipAddress == REG_IRQ_MASK);
      wr_ctrl     = ipWrEnable && (ipAddress == REG_CTRL);
      wr_scratch  = ipWrEnable && is_scratch;
      rd_cnt_lo   = ipRdEnable && (ipAddress == REG_CNT_LO);
   end

   generate
      for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
         logic [DW-1:0] data_reg;
         always_ff @(posedge ipClk or negedge ipnReset) begin
            if (!ipnReset) begin
               data_reg <= '0;
            end else if (wr_scratch && (scratch_sel == SW'(gi))) begin
               data_reg <= ipWrData;
            end
         end
         assign scratch_val[gi] = data_reg;
      end
   endgenerate

   // Counter, overflow and events: set conditions win over same-cycle clears.
   always_comb begin
      clear_cmd   = wr_ctrl && ipWrData[CTRL_CLEAR];
      wrap        = run_reg && !clear_cmd && (&cnt_reg);
      cnt_next    = cnt_reg;
      ovf_next    = ovf_reg;
      events_next = events_reg;
      if (clear_cmd) begin
         cnt_next = '0;
      end else if (run_reg) begin
         cnt_next = cnt_reg + CNT_WIDTH'(1);
      end
      if (wr_ctrl && ipWrData[CTRL_OVF]) begin
         ovf_next = 1'b0;
      end
      if (wrap) begin
         ovf_next = 1'b1;
      end
      if (wr_events) begin
         events_next = events_reg & ~ipWrData[NUM_BUTTONS-1:0];
      end
      events_next = events_next | btn_rise;
   end

   always_comb begin
      rd_mux = '0;
      case (ipAddress)
         REG_ID:       rd_mux = DW'(ID_VALUE);
         REG_LED:      rd_mux = DW'(led_reg);
         REG_BTN_LIVE: rd_mux = DW'(btn_level);
         REG_EVENTS:   rd_mux = DW'(events_reg);
         REG_IRQ_MASK: rd_mux = DW'(irq_mask_reg);
         REG_CNT_LO:   rd_mux = cnt_reg[DW-1:0];
         REG_CNT_HI:   rd_mux = DW'(cnt_hi_reg);
         REG_CTRL:     rd_mux = DW'({ovf_reg, 1'b0, run_reg});
         default: begin
            if (is_scratch) begin
               rd_mux = scratch_val[scratch_sel];
            end
         end
      endcase
   end

   always_ff @(posedge ipClk or negedge ipnReset) begin
      if (!ipnReset) begin
         led_reg      <= '0;
         events_reg   <= '0;
         irq_mask_reg <= '0;
         cnt_reg      <= '0;
         cnt_hi_reg   <= '0;
         run_reg      <= 1'b1;
         ovf_reg      <= 1'b0;
         irq_reg      <= 1'b0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
         addr_err_reg <= 1'b0;
      end else begin
         if (wr_led) begin
            led_reg <= ipWrData[NUM_LEDS-1:0];
         end
         if (wr_mask) begin
            irq_mask_reg <= ipWrData[NUM_BUTTONS-1:0];
         end
         if (wr_ctrl) begin
            run_reg <= ipWrData[CTRL_RUN];
         end
         // Reading the low word freezes the high word for a tear-free wide read.
         if (rd_cnt_lo) begin
            cnt_hi_reg <= cnt_reg[CNT_WIDTH-1:DW];
         end
         events_reg   <= events_next;
         cnt_reg      <= cnt_next;
         ovf_reg      <= ovf_next;
         irq_reg      <= |(events_reg & irq_mask_reg);
         rd_valid_reg <= ipRdEnable;
         rd_data_reg  <= ipRdEnable ? rd_mux : '0;
         addr_err_reg <= (ipRdEnable || ipWrEnable) && !mapped;
      end
   end

   assign opRdData  = rd_data_reg;
   assign opRdValid = rd_valid_reg;
   assign opAddrErr = addr_err_reg;
   assign opLED     = led_reg;
   assign opIrq     = irq_reg;

endmodule
